alu_result_display: RTL

- Downstream consumer of the ALU output register (registered result, cout, negative, zero). Drives the board's multiplexed common-anode 7-segment display and three flag LEDs.
- Takes a snapshot of the registered ALU outputs once per scan frame so digits never tear mid-frame.
- Converts each 4-bit nibble to hex segments and time-multiplexes the digits with a prescaled scan counter.

---
 rtl/alu_result_display.sv | 137 +++++++++++++
 1 files changed

// File: rtl/alu_result_display.sv
// Snapshots the registered ALU result/flags once per scan frame and drives a
// multiplexed common-anode hex display. `ALU_DISP_BLANK_EN enables leading-zero blanking.

module alu_disp_digit (
  input  logic [3:0] nib_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);
  logic [6:0] dec;

  // Active-low {g,f,e,d,c,b,a}; lowercase b and d.
  always_comb begin
    dec = 7'h7F;
    unique case (nib_i)
      4'h0: dec = 7'b1000000;
      4'h1: dec = 7'b1111001;
      4'h2: dec = 7'b0100100;
      4'h3: dec = 7'b0110000;
      4'h4: dec = 7'b0011001;
      4'h5: dec = 7'b0010010;
      4'h6: dec = 7'b0000010;
      4'h7: dec = 7'b1111000;
      4'h8: dec = 7'b0000000;
      4'h9: dec = 7'b0010000;
      4'hA: dec = 7'b0001000;
      4'hB: dec = 7'b0000011;
      4'hC: dec = 7'b1000110;
      4'hD: dec = 7'b0100001;
      4'hE: dec = 7'b0000110;
      4'hF: dec = 7'b0001110;
      default: dec = 7'h7F;
    endcase
  end

  assign seg_o = blank_i ? 7'h7F : dec;
endmodule

module alu_result_display #(
  parameter  int width    = 4,
  parameter  int SCAN_DIV = 50000,
  localparam int NUM_DIG  = (width + 3) / 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [width-1:0]   result_in,
  input  logic               cout_in,
  input  logic               negative_in,
  input  logic               zero_in,
  input  logic               hold,
  output logic [6:0]         seg_n,
  output logic [NUM_DIG-1:0] an_n,
  output logic [2:0]         led_flags
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;

  logic [PW-1:0]             presc_q, presc_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [NUM_DIG-1:0][3:0]   snap_q, snap_d;
  logic [2:0]                flags_q, flags_d;
  logic [6:0]                seg_q, seg_d;
  logic [NUM_DIG-1:0]        an_q, an_d;
  logic [2:0]                led_q, led_d;

  logic                      tick, wrap;
  logic [4*NUM_DIG-1:0]      ext;
  logic [NUM_DIG-1:0]        blank;
  logic [NUM_DIG-1:0][6:0]   seg_all;

  assign tick = (presc_q == PW'(SCAN_DIV - 1));
  assign wrap = tick && (idx_q == IW'(NUM_DIG - 1));

  always_comb begin
    ext = '0;
    ext[width-1:0] = result_in;
  end

`ifdef ALU_DISP_BLANK_EN
  // hz[i]: nibble i and every nibble above it are zero.
  logic [NUM_DIG:0] hz;
  assign hz[NUM_DIG] = 1'b1;
  for (genvar i = NUM_DIG - 1; i >= 0; i--) begin : g_hz
    assign hz[i] = hz[i+1] & (snap_q[i] == 4'h0);
    assign blank[i] = (i > 0) ? hz[i] : 1'b0;
  end
`else
  assign blank = '0;
`endif

  for (genvar i = 0; i < NUM_DIG; i++) begin : g_dig
    alu_disp_digit u_dig (
      .nib_i   (snap_q[i]),
      .blank_i (blank[i]),
      .seg_o   (seg_all[i])
    );
  end

  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
    idx_d   = idx_q;
    if (tick) idx_d = (idx_q == IW'(NUM_DIG - 1)) ? '0 : idx_q + 1'b1;
    snap_d  = snap_q;
    flags_d = flags_q;
    if (wrap && !hold) begin
      snap_d  = ext;
      flags_d = {cout_in, negative_in, zero_in};
    end
    // Outputs are built from this cycle's state and appear one edge later.
    an_d  = ~(NUM_DIG'(1) << idx_q);
    seg_d = seg_all[idx_q];
    led_d = flags_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      idx_q   <= '0;
      snap_q  <= '0;
      flags_q <= '0;
      seg_q   <= 7'h7F;
      an_q    <= '1;
      led_q   <= '0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      flags_q <= flags_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      led_q   <= led_d;
    end
  end

  assign seg_n     = seg_q;
  assign an_n      = an_q;
  assign led_flags = led_q;
endmodule
